mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and external bus signals of the memory arbiter
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_stallreq;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_stallreq;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, bus_ack, bus_rdata,
        input  if_rdata, if_stallreq, mem_rdata, mem_stallreq,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, bus_ack, bus_rdata,
        output if_rdata, if_stallreq, mem_rdata, mem_stallreq,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_sel
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serializes fetch and load/store ports onto one req/ack memory bus
module mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic         flush,
    mem_arbiter_if.slave arb
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_IF_BUS  = 2'd1;
    localparam logic [1:0] S_MEM_BUS = 2'd2;

    logic [1:0] state;
    logic       if_done;
    logic       mem_done;
    logic       if_discard;

    // Only stall[1] (IF/ID) and stall[4] (MEM/WB) matter here.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

    // Built from registered flags only, so no loop forms through the pipeline controller.
    assign arb.if_stallreq  = arb.if_req & ~if_done;
    assign arb.mem_stallreq = arb.mem_req & ~mem_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            if_done       <= 1'b0;
            mem_done      <= 1'b0;
            if_discard    <= 1'b0;
            arb.bus_req   <= 1'b0;
            arb.bus_we    <= 1'b0;
            arb.bus_addr  <= 32'h0;
            arb.bus_wdata <= 32'h0;
            arb.bus_sel   <= 4'h0;
            arb.if_rdata  <= 32'h0;
            arb.mem_rdata <= 32'h0;
        end else begin
            // A result is held until its stage advances; flush drops a pending fetch result.
            if (flush || (if_done && !stall[1])) begin
                if_done <= 1'b0;
            end
            if (mem_done && !stall[4]) begin
                mem_done <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (arb.mem_req && !mem_done) begin
                        arb.bus_req   <= 1'b1;
                        arb.bus_we    <= arb.mem_we;
                        arb.bus_addr  <= arb.mem_addr;
                        arb.bus_wdata <= arb.mem_wdata;
                        arb.bus_sel   <= arb.mem_sel;
                        state         <= S_MEM_BUS;
                    end else if (arb.if_req && !if_done && !flush) begin
                        arb.bus_req   <= 1'b1;
                        arb.bus_we    <= 1'b0;
                        arb.bus_addr  <= arb.if_addr;
                        arb.bus_wdata <= 32'h0;
                        arb.bus_sel   <= 4'hF;
                        state         <= S_IF_BUS;
                    end else begin
                        arb.bus_req <= 1'b0;
                    end
                end

                S_IF_BUS: begin
                    // The bus cycle always runs to its ack; a flush only marks the result as stale.
                    if (flush) begin
                        if_discard <= 1'b1;
                    end
                    if (arb.bus_ack) begin
                        arb.bus_req <= 1'b0;
                        state       <= S_IDLE;
                        if (if_discard || flush) begin
                            if_discard <= 1'b0;
                        end else begin
                            if_done      <= 1'b1;
                            arb.if_rdata <= arb.bus_rdata;
                        end
                    end
                end

                S_MEM_BUS: begin
                    if (arb.bus_ack) begin
                        arb.bus_req <= 1'b0;
                        state       <= S_IDLE;
                        mem_done    <= 1'b1;
                        if (!arb.bus_we) begin
                            arb.mem_rdata <= arb.bus_rdata;
                        end
                    end
                end

                default: begin
                    arb.bus_req <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - vector table, corner sequences and randomized pipeline model for mem_arbiter
module tb_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] stall;
    logic       flush;

    mem_arbiter_if ab();

    mem_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .arb   (ab)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic        flush;
        logic        ifq;
        logic [31:0] ifa;
        logic        mq;
        logic        mwe;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic [3:0]  msel;
        logic        ack;
        logic [31:0] rd;
        logic        breq;
        logic        bwe;
        logic [31:0] baddr;
        logic [3:0]  bsel;
        logic [31:0] bwd;
        logic        ifs;
        logic        mss;
        logic [31:0] ifr;
        logic [31:0] mr;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] st, input logic fl,
                       input logic iq, input logic [31:0] ia,
                       input logic mq, input logic mw, input logic [31:0] ma, input logic [31:0] md,
                       input logic [3:0] msl, input logic ak, input logic [31:0] rd,
                       input logic breq, input logic bwe, input logic [31:0] baddr, input logic [3:0] bsel,
                       input logic [31:0] bwd, input logic ifs, input logic mss,
                       input logic [31:0] ifr, input logic [31:0] mr);
        vec_t v;
        v.rst = r;    v.stall = st; v.flush = fl; v.ifq = iq;   v.ifa = ia;
        v.mq = mq;    v.mwe = mw;   v.ma = ma;    v.mwd = md;   v.msel = msl;
        v.ack = ak;   v.rd = rd;
        v.breq = breq; v.bwe = bwe; v.baddr = baddr; v.bsel = bsel; v.bwd = bwd;
        v.ifs = ifs;  v.mss = mss;  v.ifr = ifr;  v.mr = mr;
        tv.push_back(v);
    endtask

    task automatic drive_vec(input vec_t v);
        rst          = v.rst;
        stall        = v.stall;
        flush        = v.flush;
        ab.if_req    = v.ifq;
        ab.if_addr   = v.ifa;
        ab.mem_req   = v.mq;
        ab.mem_we    = v.mwe;
        ab.mem_addr  = v.ma;
        ab.mem_wdata = v.mwd;
        ab.mem_sel   = v.msel;
        ab.bus_ack   = v.ack;
        ab.bus_rdata = v.rd;
    endtask

    // Reference memory contents: fetch region is a fixed function of the address.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    logic [31:0] slave_ram [256];
    logic [31:0] arch_ram  [256];

    initial begin
        logic [159:0] act, exp;
        logic [31:0]  last_load;
        logic [68:0]  snap;
        logic         busy, just_acked, if_adv, mem_adv, if_cpl, mem_cpl;
        int           lat, if_wait, mem_wait;
        logic [7:0]   midx;

        rst = 1'b0; stall = '0; flush = 1'b0;
        ab.if_req = 1'b0; ab.if_addr = '0; ab.mem_req = 1'b0; ab.mem_we = 1'b0;
        ab.mem_addr = '0; ab.mem_wdata = '0; ab.mem_sel = '0; ab.bus_ack = 1'b0; ab.bus_rdata = '0;

        // single fetch, ack in cycle 3
        add(1,'h00,0, 1,'h100, 0,0,'h0,'h0,'h0, 0,'h0,         0,0,'h000,'h0,'h0, 1,0,'h0,'h0);
        add(1,'h00,0, 1,'h100, 0,0,'h0,'h0,'h0, 0,'h0,         1,0,'h100,'hF,'h0, 1,0,'h0,'h0);
        add(1,'h00,0, 1,'h100, 0,0,'h0,'h0,'h0, 0,'h0,         1,0,'h100,'hF,'h0, 1,0,'h0,'h0);
        add(1,'h00,0, 1,'h100, 0,0,'h0,'h0,'h0, 1,'h24020005,  1,0,'h100,'hF,'h0, 1,0,'h0,'h0);
        add(1,'h00,0, 1,'h100, 0,0,'h0,'h0,'h0, 0,'h0,         0,0,'h100,'hF,'h0, 0,0,'h24020005,'h0);
        add(1,'h00,0, 0,'h100, 0,0,'h0,'h0,'h0, 0,'h0,         0,0,'h100,'hF,'h0, 0,0,'h24020005,'h0);
        // simultaneous requests: MEM first, IF after
        add(1,'h00,0, 1,'h104, 1,0,'h200,'h0,'hF, 0,'h0,        0,0,'h100,'hF,'h0, 1,1,'h24020005,'h0);
        add(1,'h00,0, 1,'h104, 1,0,'h200,'h0,'hF, 0,'h0,        1,0,'h200,'hF,'h0, 1,1,'h24020005,'h0);
        add(1,'h00,0, 1,'h104, 1,0,'h200,'h0,'hF, 1,'h11223344, 1,0,'h200,'hF,'h0, 1,1,'h24020005,'h0);
        add(1,'h00,0, 1,'h104, 1,0,'h200,'h0,'hF, 0,'h0,        0,0,'h200,'hF,'h0, 1,0,'h24020005,'h11223344);
        add(1,'h00,0, 1,'h104, 0,0,'h200,'h0,'hF, 0,'h0,        1,0,'h104,'hF,'h0, 1,0,'h24020005,'h11223344);
        add(1,'h00,0, 1,'h104, 0,0,'h200,'h0,'hF, 1,'hCAFEF00D, 1,0,'h104,'hF,'h0, 1,0,'h24020005,'h11223344);
        add(1,'h00,0, 1,'h104, 0,0,'h200,'h0,'hF, 0,'h0,        0,0,'h104,'hF,'h0, 0,0,'hCAFEF00D,'h11223344);
        add(1,'h00,0, 0,'h104, 0,0,'h200,'h0,'hF, 0,'h0,        0,0,'h104,'hF,'h0, 0,0,'hCAFEF00D,'h11223344);
        // load 0x55, then a store leaves mem_rdata alone
        add(1,'h00,0, 0,'h0, 1,0,'h300,'h0,'hF, 0,'h0,          0,0,'h104,'hF,'h0, 0,1,'hCAFEF00D,'h11223344);
        add(1,'h00,0, 0,'h0, 1,0,'h300,'h0,'hF, 1,'h55,         1,0,'h300,'hF,'h0, 0,1,'hCAFEF00D,'h11223344);
        add(1,'h00,0, 0,'h0, 1,0,'h300,'h0,'hF, 0,'h0,          0,0,'h300,'hF,'h0, 0,0,'hCAFEF00D,'h55);
        add(1,'h00,0, 0,'h0, 1,1,'h304,'hABCD1234,'h3, 0,'h0,   0,0,'h300,'hF,'h0, 0,1,'hCAFEF00D,'h55);
        add(1,'h00,0, 0,'h0, 1,1,'h304,'hABCD1234,'h3, 1,'hDEADBEEF, 1,1,'h304,'h3,'hABCD1234, 0,1,'hCAFEF00D,'h55);
        add(1,'h00,0, 0,'h0, 1,1,'h304,'hABCD1234,'h3, 0,'h0,   0,1,'h304,'h3,'h0, 0,0,'hCAFEF00D,'h55);
        add(1,'h00,0, 0,'h0, 0,1,'h304,'hABCD1234,'h3, 0,'h0,   0,1,'h304,'h3,'h0, 0,0,'hCAFEF00D,'h55);
        // flush in cycle 2 of a fetch acked in cycle 4, then refetch
        add(1,'h00,0, 1,'h400, 0,0,'h0,'h0,'h0, 0,'h0,         0,1,'h304,'h3,'h0, 1,0,'hCAFEF00D,'h55);
        add(1,'h00,0, 1,'h400, 0,0,'h0,'h0,'h0, 0,'h0,         1,0,'h400,'hF,'h0, 1,0,'hCAFEF00D,'h55);
        add(1,'h00,1, 1,'h400, 0,0,'h0,'h0,'h0, 0,'h0,         1,0,'h400,'hF,'h0, 1,0,'hCAFEF00D,'h55);
        add(1,'h00,0, 1,'h500, 0,0,'h0,'h0,'h0, 0,'h0,         1,0,'h400,'hF,'h0, 1,0,'hCAFEF00D,'h55);
        add(1,'h00,0, 1,'h500, 0,0,'h0,'h0,'h0, 1,'hBAD0BAD0,  1,0,'h400,'hF,'h0, 1,0,'hCAFEF00D,'h55);
        add(1,'h00,0, 1,'h500, 0,0,'h0,'h0,'h0, 0,'h0,         0,0,'h400,'hF,'h0, 1,0,'hCAFEF00D,'h55);
        // ack while IF/ID is held: result stays, no new fetch until release
        add(1,'h02,0, 1,'h500, 0,0,'h0,'h0,'h0, 1,'h13579BDF,  1,0,'h500,'hF,'h0, 1,0,'hCAFEF00D,'h55);
        add(1,'h02,0, 1,'h500, 0,0,'h0,'h0,'h0, 0,'h0,         0,0,'h500,'hF,'h0, 0,0,'h13579BDF,'h55);
        add(1,'h02,0, 1,'h500, 0,0,'h0,'h0,'h0, 0,'h0,         0,0,'h500,'hF,'h0, 0,0,'h13579BDF,'h55);
        add(1,'h00,0, 1,'h500, 0,0,'h0,'h0,'h0, 0,'h0,         0,0,'h500,'hF,'h0, 0,0,'h13579BDF,'h55);
        add(1,'h00,0, 1,'h504, 0,0,'h0,'h0,'h0, 0,'h0,         0,0,'h500,'hF,'h0, 1,0,'h13579BDF,'h55);
        add(1,'h00,0, 1,'h504, 0,0,'h0,'h0,'h0, 1,'h600D600D,  1,0,'h504,'hF,'h0, 1,0,'h13579BDF,'h55);
        add(1,'h00,0, 1,'h504, 0,0,'h0,'h0,'h0, 0,'h0,         0,0,'h504,'hF,'h0, 0,0,'h600D600D,'h55);
        add(1,'h00,0, 0,'h504, 0,0,'h0,'h0,'h0, 0,'h0,         0,0,'h504,'hF,'h0, 0,0,'h600D600D,'h55);
        // reset in cycle 2 of a MEM bus cycle; the late ack is ignored
        add(1,'h00,0, 0,'h0, 1,0,'h700,'h0,'hF, 0,'h0,          0,0,'h504,'hF,'h0, 0,1,'h600D600D,'h55);
        add(1,'h00,0, 0,'h0, 1,0,'h700,'h0,'hF, 0,'h0,          1,0,'h700,'hF,'h0, 0,1,'h600D600D,'h55);
        add(0,'h00,0, 0,'h0, 1,0,'h700,'h0,'hF, 0,'h0,          1,0,'h700,'hF,'h0, 0,1,'h600D600D,'h55);
        add(1,'h00,0, 0,'h0, 0,0,'h700,'h0,'hF, 1,'hFFFFFFFF,   0,0,'h000,'h0,'h0, 0,0,'h0,'h0);
        add(1,'h00,0, 0,'h0, 0,0,'h700,'h0,'hF, 0,'h0,          0,0,'h000,'h0,'h0, 0,0,'h0,'h0);

        repeat (2) @(posedge clk);
        foreach (tv[i]) begin
            @(posedge clk); #1;
            drive_vec(tv[i]);
            #1;
            act = {ab.bus_req, ab.bus_we, ab.bus_addr, ab.bus_sel,
                   (tv[i].breq & tv[i].bwe) ? ab.bus_wdata : 32'h0,
                   ab.if_stallreq, ab.mem_stallreq, ab.if_rdata, ab.mem_rdata};
            exp = {tv[i].breq, tv[i].bwe, tv[i].baddr, tv[i].bsel,
                   (tv[i].breq & tv[i].bwe) ? tv[i].bwd : 32'h0,
                   tv[i].ifs, tv[i].mss, tv[i].ifr, tv[i].mr};
            chk($sformatf("vec%0d", i), act, exp);
        end

        // Randomized run: the bench plays both pipeline and memory, and checks results against
        // an architectural memory updated only when the pipeline retires a store.
        rst = 1'b0; ab.if_req = 1'b0; ab.mem_req = 1'b0; ab.bus_ack = 1'b0; flush = 1'b0; stall = '0;
        for (int i = 0; i < 256; i++) begin
            slave_ram[i] = $urandom;
            arch_ram[i]  = slave_ram[i];
        end
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        last_load = 32'h0;
        busy = 1'b0; just_acked = 1'b0; if_adv = 1'b1; mem_adv = 1'b1;
        lat = 0; if_wait = 0; mem_wait = 0; snap = '0;

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (if_adv) begin
                ab.if_req  = ($urandom_range(0, 3) != 0);
                ab.if_addr = 32'h1000 | ($urandom_range(0, 255) << 2);
                if_wait    = 0;
            end
            if (mem_adv) begin
                ab.mem_req   = ($urandom_range(0, 3) != 0);
                ab.mem_we    = $urandom_range(0, 1) != 0;
                ab.mem_addr  = $urandom_range(0, 255) << 2;
                ab.mem_wdata = $urandom;
                ab.mem_sel   = 4'($urandom_range(1, 15));
                mem_wait     = 0;
            end

            ab.bus_ack   = 1'b0;
            ab.bus_rdata = $urandom;
            if (just_acked) chk("bus_idle_after_ack", ab.bus_req, 0);
            just_acked = 1'b0;
            if (ab.bus_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    lat  = $urandom_range(0, 3);
                    snap = {ab.bus_we, ab.bus_addr, ab.bus_wdata, ab.bus_sel};
                    if (ab.bus_addr[12]) chk("fetch_bus_attr", {ab.bus_we, ab.bus_sel}, {1'b0, 4'hF});
                end else begin
                    chk("bus_stable", {ab.bus_we, ab.bus_addr, ab.bus_wdata, ab.bus_sel}, snap);
                end
                if (lat == 0) begin
                    ab.bus_ack = 1'b1;
                    if (ab.bus_addr[12]) ab.bus_rdata = rom(ab.bus_addr);
                    else if (!ab.bus_we) ab.bus_rdata = slave_ram[ab.bus_addr[9:2]];
                    else slave_ram[ab.bus_addr[9:2]] = merge(slave_ram[ab.bus_addr[9:2]], ab.bus_wdata, ab.bus_sel);
                    busy       = 1'b0;
                    just_acked = 1'b1;
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                ab.bus_ack = 1'b1;
            end
            #1;

            midx    = ab.mem_addr[9:2];
            if_cpl  = ab.if_req && !ab.if_stallreq;
            mem_cpl = ab.mem_req && !ab.mem_stallreq;
            if (if_cpl) chk("fetch_data", ab.if_rdata, rom(ab.if_addr));
            if (mem_cpl) begin
                if (ab.mem_we) chk("store_keeps_rdata", ab.mem_rdata, last_load);
                else           chk("load_data", ab.mem_rdata, arch_ram[midx]);
            end
            if (ab.if_req && ab.if_stallreq) if_wait++;
            if (ab.mem_req && ab.mem_stallreq) mem_wait++;
            if (if_wait > 200) begin
                total++; bad++;
                $display("FAIL fetch_progress: waited %0d cycles, limit 200", if_wait);
                if_wait = 0;
            end
            if (mem_wait > 200) begin
                total++; bad++;
                $display("FAIL mem_progress: waited %0d cycles, limit 200", mem_wait);
                mem_wait = 0;
            end

            stall    = 6'($urandom_range(0, 63));
            stall[1] = ($urandom_range(0, 2) == 0);
            stall[4] = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            if_adv   = flush || !ab.if_req || (if_cpl && !stall[1]);
            mem_adv  = !ab.mem_req || (mem_cpl && !stall[4]);
            if (mem_cpl && !stall[4]) begin
                if (ab.mem_we) arch_ram[midx] = merge(arch_ram[midx], ab.mem_wdata, ab.mem_sel);
                else           last_load = arch_ram[midx];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
